regfile_mp_scoreboard: RTL and testbench
========================================

// Module: regfile_mp_scoreboard
// PURPOSE
//  Parametrised multi-port integer register file for the pipelined core: NRD async read
//  ports, NWR write ports with same-cycle write->read bypass, and a per-register pending-
//  write scoreboard (issue increments, writeback decrements) driving decode stalls.
//  Replaces the single-write, non-resettable register file; keeps the x0 and debug-dump contract.
// PARAMETERS
//  XLEN   64  data width in bits
//  NREG   32  architectural registers; index width AW = $clog2(NREG)
//  NRD     2  read ports
//  NWR     1  write ports; higher port index wins a same-register conflict
//  PCW     2  pending-counter width; at most 2**PCW-1 in-flight writes per register
//  BYPASS  1  1 = a read returns the data being written this cycle; 0 = it returns the stored value
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high
//  rd_idx     in   NRD*AW     read addresses, packed per port
//  rd_data    out  NRD*XLEN   read data, combinational
//  rd_busy    out  NRD        pending write outstanding on rd_idx[i]
//  wr_en      in   NWR        write enables
//  wr_idx     in   NWR*AW     write addresses
//  wr_data    in   NWR*XLEN   write data
//  iss_valid  in   1          decode issues an instruction that writes iss_rd
//  iss_rd     in   AW         destination of the issued instruction
//  iss_stall  out  1          iss_rd counter saturated; issue refused this cycle
//  dbg_regs   out  NREG*XLEN  flat dump of all registers; maps onto reg_t when NREG=32, XLEN=64
// BEHAVIOUR
//  Reset: all registers 0 and all pending counters 0 at the first edge with reset=1.
//   Reset overrides wr_en and iss_valid on that edge. dbg_regs, rd_data and rd_busy read 0.
//  Write: on posedge, if wr_en[j] and wr_idx[j]!=0, then reg[wr_idx[j]] <= wr_data[j].
//   Same index on several ports: the highest j wins. Writes to x0 are dropped silently.
//  Read: rd_data[i] = 0 if rd_idx[i]==0.
//   Else if BYPASS and some wr_en[j] targets rd_idx[i], it returns that wr_data (highest j wins).
//   Else it returns the stored value. Zero-cycle latency.
//  Scoreboard: pcnt[r] is PCW bits wide. Index 0 is never counted.
//   inc = iss_valid && iss_rd!=0 && !iss_stall.
//   dec[r] = number of wr_en ports targeting r, counted once per register even if several
//    ports hit it, and only when pcnt[r]!=0.
//   pcnt[r] <= pcnt[r] + inc_r - dec_r. Simultaneous inc and dec on one register leaves
//    it unchanged.
//   Writeback with pcnt==0 (untracked write) updates data but leaves the counter at 0. No underflow.
//  iss_stall = iss_valid && iss_rd!=0 && pcnt[iss_rd]==2**PCW-1 && !dec[iss_rd].
//   Combinational. A same-cycle writeback frees the slot.
//  rd_busy[i] = pcnt[rd_idx[i]]!=0 && !(BYPASS && this-cycle write to rd_idx[i] with pcnt==1).
//   The last pending write, when bypassed, is not reported as busy.
//  Reset mid-operation: in-flight counts are discarded. Writebacks that arrive later are
//   untracked and obey the no-underflow rule.
//  No X propagation: out-of-range indices (NREG not a power of 2) read 0 and are never written.
// STRUCTURE
//  Shared package common: typedef logic [XLEN-1:0] word_t; typedef logic [AW-1:0] ridx_t;
//   localparam PCMAX. reg_t stays in common and is built from dbg_regs by the top level.
//  Sub-module reg_pending_ctr (one per register, r=1..NREG-1): inputs inc, dec, reset;
//   outputs cnt, busy, full. Holds all saturation and underflow rules.
//  Top level holds the data array, the write-priority mux, the bypass mux and the stall logic.
//  Target 150-300 lines.
// TESTING
//  1 reset=1 one cycle -> every dbg_regs word 0. rd_idx=5 -> rd_data 0, rd_busy 0, iss_stall 0.
//  2 wr x7=0xDEAD_BEEF, rd_idx0=7 same cycle (BYPASS=1) -> 0xDEADBEEF immediately.
//    BYPASS=0 -> old value this cycle, 0xDEADBEEF the next cycle.
//  3 wr x0=0x1234 -> rd x0=0 and dbg_regs[0]=0.
//    NWR=2, both ports write x3 (0xA, 0xB) -> x3=0xB.
//  4 issue x9 three times (PCW=2) -> pcnt=3.
//    Fourth issue -> iss_stall=1, pcnt stays 3.
//    Fourth issue plus wr x9 the same cycle -> iss_stall=0, pcnt stays 3.
//  5 pcnt[4]=1, wr x4 with rd_idx=4 -> rd_busy=0 and bypassed data.
//    Next cycle pcnt=0. A further wr x4 -> pcnt stays 0, no underflow.
//  6 issue x12 twice, reset=1 with wr_en on x12 the same edge -> x12=0, pcnt=0.
//    A later wr x12 stores data, pcnt stays 0.

Source files
------------

// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared types and default sizing for the multi-port register file.
// reg_t gives a structured view of the flat debug dump at default sizing.
package regfile_mp_scoreboard_pkg;

    localparam int DEF_XLEN = 64;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = $clog2(DEF_NREG);
    localparam int DEF_PCW  = 2;
    localparam int PCMAX    = 2 ** DEF_PCW - 1;

    typedef logic [DEF_XLEN-1:0] word_t;
    typedef logic [DEF_AW-1:0]   ridx_t;
    typedef word_t [DEF_NREG-1:0] reg_t;

endpackage

// File: rtl/regfile_mp_scoreboard_ctr.sv
// Per-register pending-write counter.
// Saturates at all-ones and never underflows.
module reg_pending_ctr
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int PCW = DEF_PCW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inc,
    input  logic           dec,
    output logic [PCW-1:0] cnt,
    output logic           busy,
    output logic           full
);

    logic dec_ok;
    logic inc_ok;

    assign busy   = cnt != '0;
    assign full   = cnt == {PCW{1'b1}};
    // A writeback with nothing pending is untracked; a full counter
    // accepts a new issue only when a writeback frees a slot.
    assign dec_ok = dec && busy;
    assign inc_ok = inc && !(full && !dec_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc_ok && !dec_ok) begin
            cnt <= cnt + PCW'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt <= cnt - PCW'(1);
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write->read bypass
// and a per-register pending-write scoreboard for decode stalls.
module regfile_mp_scoreboard
    import regfile_mp_scoreboard_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int PCW    = DEF_PCW,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_idx,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_idx,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_stall,
    output logic [NREG*XLEN-1:0] dbg_regs
);

    logic [XLEN-1:0] q    [NREG];
    logic [XLEN-1:0] wval [NREG];
    logic [PCW-1:0]  cnt  [NREG];
    logic [NREG-1:0] whit;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] full;

    // Later ports overwrite earlier ones, so the highest port wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            whit[r] = 1'b0;
            wval[r] = '0;
        end
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_idx[j*AW +: AW] == AW'(r)) begin
                    whit[r] = 1'b1;
                    wval[r] = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_reg
            if (g == 0) begin : g_zero
                assign q[g]    = '0;
                assign cnt[g]  = '0;
                assign busy[g] = 1'b0;
                assign full[g] = 1'b0;
            end else begin : g_live
                always_ff @(posedge clk) begin
                    if (reset) begin
                        q[g] <= '0;
                    end else if (whit[g]) begin
                        q[g] <= wval[g];
                    end
                end

                reg_pending_ctr #(
                    .PCW (PCW)
                ) u_ctr (
                    .clk   (clk),
                    .reset (reset),
                    .inc   (iss_valid && iss_rd == AW'(g)),
                    .dec   (whit[g]),
                    .cnt   (cnt[g]),
                    .busy  (busy[g]),
                    .full  (full[g])
                );
            end
            assign dbg_regs[g*XLEN +: XLEN] = q[g];
        end
    endgenerate

    // Index match by scan keeps out-of-range indices at zero.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 0; r < NREG; r++) begin
                if (rd_idx[i*AW +: AW] == AW'(r)) begin
                    rd_data[i*XLEN +: XLEN] =
                        (BYPASS != 0 && whit[r]) ? wval[r] : q[r];
                    rd_busy[i] = busy[r] &&
                        !(BYPASS != 0 && whit[r] && cnt[r] == PCW'(1));
                end
            end
        end
    end

    always_comb begin
        iss_stall = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            if (iss_rd == AW'(r)) begin
                iss_stall = iss_valid && full[r] && !whit[r];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed table plus randomized traffic against a reference model,
// driving a bypassing and a non-bypassing instance in parallel.
module tb_regfile_mp_scoreboard;

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wi0;
        logic [63:0] wd0;
        logic [4:0]  wi1;
        logic [63:0] wd1;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  ri0;
        logic [4:0]  ri1;
        logic [63:0] ed;
        logic        eb;
        logic        est;
        logic [63:0] ednb;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [9:0]    rd_idx;
    logic [1:0]    wr_en;
    logic [9:0]    wr_idx;
    logic [127:0]  wr_data;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic [127:0]  rd_data_a;
    logic [1:0]    rd_busy_a;
    logic          iss_stall_a;
    logic [2047:0] dbg_a;
    logic [127:0]  rd_data_b;
    logic [1:0]    rd_busy_b;
    logic          iss_stall_b;
    logic [2047:0] dbg_b;

    logic [63:0] mreg [32];
    int          mcnt [32];
    vec_t        tbl  [24];
    int          n_vec;
    int          n_err;

    regfile_mp_scoreboard #(
        .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .PCW(2), .BYPASS(1)
    ) u_dut (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_a),
        .rd_busy(rd_busy_a), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_stall(iss_stall_a), .dbg_regs(dbg_a)
    );

    regfile_mp_scoreboard #(
        .XLEN(64), .NREG(32), .NRD(2), .NWR(2), .PCW(2), .BYPASS(0)
    ) u_nb (
        .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_data(wr_data), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_stall(iss_stall_b), .dbg_regs(dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic rst, input logic [1:0] we,
        input logic [4:0] wi0, input logic [63:0] wd0,
        input logic [4:0] wi1, input logic [63:0] wd1,
        input logic iv, input logic [4:0] ir,
        input logic [4:0] ri0, input logic [4:0] ri1,
        input logic [63:0] ed, input logic eb, input logic est,
        input logic [63:0] ednb);
        vec_t t;
        t.rst = rst; t.we = we; t.wi0 = wi0; t.wd0 = wd0;
        t.wi1 = wi1; t.wd1 = wd1; t.iv = iv; t.ir = ir;
        t.ri0 = ri0; t.ri1 = ri1; t.ed = ed; t.eb = eb;
        t.est = est; t.ednb = ednb;
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Last matching port wins, as the write rules require.
    function automatic logic mhit(input int r, output logic [63:0] val);
        logic h;
        h = 1'b0;
        val = '0;
        if (r != 0) begin
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j] && int'(wr_idx[j*5 +: 5]) == r) begin
                    h = 1'b1;
                    val = wr_data[j*64 +: 64];
                end
            end
        end
        return h;
    endfunction

    function automatic logic mstall();
        logic [63:0] dummy;
        int r;
        r = int'(iss_rd);
        return iss_valid && r != 0 && mcnt[r] == 3 && !mhit(r, dummy);
    endfunction

    task automatic check_model();
        logic [63:0] val;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic        h;
        logic        ba;
        logic        bb;
        int          idx;
        int          bad;
        for (int i = 0; i < 2; i++) begin
            idx = int'(rd_idx[i*5 +: 5]);
            h = mhit(idx, val);
            exp_a = (idx == 0) ? 64'd0 : (h ? val : mreg[idx]);
            exp_b = (idx == 0) ? 64'd0 : mreg[idx];
            ba = mcnt[idx] != 0 && !(h && mcnt[idx] == 1);
            bb = mcnt[idx] != 0;
            cmp($sformatf("rd_data_a[%0d]", i), rd_data_a[i*64 +: 64], exp_a);
            cmp($sformatf("rd_data_b[%0d]", i), rd_data_b[i*64 +: 64], exp_b);
            cmp($sformatf("rd_busy_a[%0d]", i), 64'(rd_busy_a[i]), 64'(ba));
            cmp($sformatf("rd_busy_b[%0d]", i), 64'(rd_busy_b[i]), 64'(bb));
        end
        cmp("iss_stall_a", 64'(iss_stall_a), 64'(mstall()));
        cmp("iss_stall_b", 64'(iss_stall_b), 64'(mstall()));
        bad = 0;
        for (int w = 31; w >= 0; w--) begin
            if (dbg_a[w*64 +: 64] !== mreg[w] ||
                dbg_b[w*64 +: 64] !== mreg[w]) bad = w + 1;
        end
        if (bad != 0) begin
            cmp($sformatf("dbg_regs a[%0d]", bad - 1),
                dbg_a[(bad-1)*64 +: 64], mreg[bad-1]);
            cmp($sformatf("dbg_regs b[%0d]", bad - 1),
                dbg_b[(bad-1)*64 +: 64], mreg[bad-1]);
        end else begin
            cmp("dbg_regs", dbg_a[63:0], mreg[0]);
        end
    endtask

    task automatic model_edge();
        logic [63:0] val;
        logic        h;
        logic        st;
        int          d;
        int          inc;
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                mreg[r] = '0;
                mcnt[r] = 0;
            end
        end else begin
            st = mstall();
            for (int r = 1; r < 32; r++) begin
                h = mhit(r, val);
                d = (h && mcnt[r] > 0) ? 1 : 0;
                inc = (iss_valid && int'(iss_rd) == r && !st) ? 1 : 0;
                if (h) mreg[r] = val;
                mcnt[r] = mcnt[r] + inc - d;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int r = 0; r < 32; r++) begin
            mreg[r] = '0;
            mcnt[r] = 0;
        end

        //           rst we    wi0 wd0             wi1 wd1   iv ir  ri0 ri1 ed               eb est ednb
        tbl[0]  = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  5,  0,  0,               0, 0, 0);
        tbl[1]  = v(0, 2'b01, 7,  64'hDEADBEEF,   0,  0,    0, 0,  7,  0,  64'hDEADBEEF,    0, 0, 0);
        tbl[2]  = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  7,  0,  64'hDEADBEEF,    0, 0, 64'hDEADBEEF);
        tbl[3]  = v(0, 2'b01, 0,  64'h1234,       0,  0,    0, 0,  0,  0,  0,               0, 0, 0);
        tbl[4]  = v(0, 2'b11, 3,  64'hA,          3,  64'hB, 0, 0, 3,  0,  64'hB,           0, 0, 0);
        tbl[5]  = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  3,  0,  64'hB,           0, 0, 64'hB);
        tbl[6]  = v(0, 2'b00, 0,  0,              0,  0,    1, 9,  9,  0,  0,               0, 0, 0);
        tbl[7]  = v(0, 2'b00, 0,  0,              0,  0,    1, 9,  9,  0,  0,               1, 0, 0);
        tbl[8]  = v(0, 2'b00, 0,  0,              0,  0,    1, 9,  9,  0,  0,               1, 0, 0);
        tbl[9]  = v(0, 2'b00, 0,  0,              0,  0,    1, 9,  9,  0,  0,               1, 1, 0);
        tbl[10] = v(0, 2'b01, 9,  64'h99,         0,  0,    1, 9,  9,  0,  64'h99,          1, 0, 0);
        tbl[11] = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  9,  0,  64'h99,          1, 0, 64'h99);
        tbl[12] = v(0, 2'b00, 0,  0,              0,  0,    1, 9,  9,  0,  64'h99,          1, 1, 64'h99);
        tbl[13] = v(0, 2'b00, 0,  0,              0,  0,    1, 4,  4,  0,  0,               0, 0, 0);
        tbl[14] = v(0, 2'b01, 4,  64'h44,         0,  0,    0, 0,  4,  0,  64'h44,          0, 0, 0);
        tbl[15] = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  4,  0,  64'h44,          0, 0, 64'h44);
        tbl[16] = v(0, 2'b01, 4,  64'h45,         0,  0,    0, 0,  4,  0,  64'h45,          0, 0, 64'h44);
        tbl[17] = v(0, 2'b00, 0,  0,              0,  0,    1, 4,  4,  0,  64'h45,          0, 0, 64'h45);
        tbl[18] = v(0, 2'b00, 0,  0,              0,  0,    1, 12, 12, 0,  0,               0, 0, 0);
        tbl[19] = v(0, 2'b00, 0,  0,              0,  0,    1, 12, 12, 0,  0,               1, 0, 0);
        tbl[20] = v(1, 2'b01, 12, 64'hC,          0,  0,    0, 0,  12, 0,  64'hC,           1, 0, 0);
        tbl[21] = v(0, 2'b00, 0,  0,              0,  0,    0, 0,  12, 4,  0,               0, 0, 0);
        tbl[22] = v(0, 2'b01, 12, 64'hCC,         0,  0,    0, 0,  12, 0,  64'hCC,          0, 0, 0);
        tbl[23] = v(0, 2'b00, 0,  0,              0,  0,    1, 12, 12, 0,  64'hCC,          0, 0, 64'hCC);

        reset = 1'b1;
        rd_idx = '0;
        wr_en = '0;
        wr_idx = '0;
        wr_data = '0;
        iss_valid = 1'b0;
        iss_rd = '0;
        @(posedge clk);
        model_edge();
        #1;

        for (int k = 0; k < 24; k++) begin
            reset     = tbl[k].rst;
            wr_en     = tbl[k].we;
            wr_idx    = {tbl[k].wi1, tbl[k].wi0};
            wr_data   = {tbl[k].wd1, tbl[k].wd0};
            iss_valid = tbl[k].iv;
            iss_rd    = tbl[k].ir;
            rd_idx    = {tbl[k].ri1, tbl[k].ri0};
            @(negedge clk);
            cmp($sformatf("row%0d rd_data", k), rd_data_a[63:0], tbl[k].ed);
            cmp($sformatf("row%0d rd_busy", k), 64'(rd_busy_a[0]), 64'(tbl[k].eb));
            cmp($sformatf("row%0d iss_stall", k), 64'(iss_stall_a), 64'(tbl[k].est));
            cmp($sformatf("row%0d rd_data_nb", k), rd_data_b[63:0], tbl[k].ednb);
            check_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            wr_en     = 2'($urandom_range(0, 3));
            wr_idx    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            wr_data   = {$urandom, $urandom, $urandom, $urandom};
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = 5'($urandom_range(0, 15));
            rd_idx    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
